// File: rtl/pio_out_pkg.sv
// Shared register map, write-op encoding and address decode for the
// multi-width output PIO.
package pio_out_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_SET   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CLR   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_TGL   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PULSE = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PLEN  = 3'd5;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_DATA  = 3'd1,
    OP_SET   = 3'd2,
    OP_CLR   = 3'd3,
    OP_TGL   = 3'd4,
    OP_PULSE = 3'd5,
    OP_PLEN  = 3'd6
  } wr_op_e;

  // Map a register address to the write operation it performs.
  function automatic wr_op_e decode_op(input logic [ADDR_W-1:0] addr);
    wr_op_e op;
    op = OP_NONE;
    case (addr)
      ADDR_DATA:  op = OP_DATA;
      ADDR_SET:   op = OP_SET;
      ADDR_CLR:   op = OP_CLR;
      ADDR_TGL:   op = OP_TGL;
      ADDR_PULSE: op = OP_PULSE;
      ADDR_PLEN:  op = OP_PLEN;
      default:    op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pio_out_multi_if.sv
// Avalon-MM slave bus bundle for the output PIO.
interface pio_out_multi_if #(
  parameter int unsigned WIDTH = 16
);
  import pio_out_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [WIDTH-1:0]  writedata;
  logic [WIDTH-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_pulse_timer.sv
// Down-counter for the hardware pulse mode; expire flags the 1->0 edge.
module pio_pulse_timer #(
  parameter int unsigned PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               cancel,
  input  logic [PULSE_W-1:0] load_val,
  output logic               busy,
  output logic               expire
);

  logic [PULSE_W-1:0] cnt;

  // A reload on the expiry edge still reports expire so the old mask is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cancel) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - PULSE_W'(1);
    end
  end

  assign busy   = (cnt != '0);
  assign expire = (cnt == PULSE_W'(1));

endmodule

// File: rtl/pio_out_multi.sv
// Parametrised Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE and a
// self-clearing pulse mode.
module pio_out_multi
  import pio_out_pkg::*;
#(
  parameter int unsigned         WIDTH        = 16,
  parameter int unsigned         PULSE_W      = 16,
  parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
  parameter logic [PULSE_W-1:0]  DEFAULT_PLEN = PULSE_W'(1)
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_out_multi_if.slave    bus,
  output logic [WIDTH-1:0]  out_port,
  output logic              busy,
  output logic              changed
);

  wr_op_e             op;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   mask_q;
  logic [WIDTH-1:0]   mask_nxt;
  logic [WIDTH-1:0]   out_nxt;
  logic [PULSE_W-1:0] plen_q;
  logic [PULSE_W-1:0] plen_nxt;
  logic [PULSE_W-1:0] load_val;
  logic               pulse_load;
  logic               pulse_cancel;
  logic               expire;

  assign wd       = bus.writedata;
  assign load_val = (plen_q == '0) ? PULSE_W'(1) : plen_q;

  // Expiry is folded in first so a same-edge write has the final word.
  always_comb begin
    op           = OP_NONE;
    out_nxt      = out_port;
    mask_nxt     = mask_q;
    plen_nxt     = plen_q;
    pulse_load   = 1'b0;
    pulse_cancel = 1'b0;

    if (bus.chipselect && !bus.write_n) begin
      op = decode_op(bus.address);
    end

    if (expire) begin
      out_nxt  = out_port & ~mask_q;
      mask_nxt = '0;
    end

    case (op)
      OP_DATA: begin
        out_nxt      = wd;
        mask_nxt     = '0;
        pulse_cancel = 1'b1;
      end
      OP_SET: out_nxt = out_nxt | wd;
      OP_CLR: begin
        out_nxt  = out_nxt & ~wd;
        mask_nxt = mask_nxt & ~wd;
      end
      OP_TGL: out_nxt = out_nxt ^ wd;
      OP_PULSE: begin
        if (wd != '0) begin
          out_nxt    = out_nxt | wd;
          mask_nxt   = mask_nxt | wd;
          pulse_load = 1'b1;
        end
      end
      OP_PLEN: plen_nxt = wd[PULSE_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
      mask_q   <= '0;
      plen_q   <= DEFAULT_PLEN;
      changed  <= 1'b0;
    end else begin
      out_port <= out_nxt;
      mask_q   <= mask_nxt;
      plen_q   <= plen_nxt;
      changed  <= (out_nxt != out_port);
    end
  end

  pio_pulse_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pulse_load),
    .cancel   (pulse_cancel),
    .load_val (load_val),
    .busy     (busy),
    .expire   (expire)
  );

  // Zero-wait-state read mux, independent of chipselect.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:  bus.readdata = out_port;
      ADDR_PULSE: bus.readdata = mask_q;
      ADDR_PLEN:  bus.readdata = WIDTH'(plen_q);
      default:    bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_out_multi.sv
// Scoreboard bench: directed plan sequences plus random traffic against a
// deadline-based reference model.
module tb_pio_out_multi;
  import pio_out_pkg::*;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned PULSE_W = 16;
  localparam logic [15:0] RV      = 16'h00A5;
  localparam logic [15:0] DP      = 16'd1;

  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] out_port;
  logic busy;
  logic changed;

  always #5 clk = ~clk;

  pio_out_multi_if #(.WIDTH(WIDTH)) bus ();

  pio_out_multi #(
    .WIDTH        (WIDTH),
    .PULSE_W      (PULSE_W),
    .RESET_VALUE  (RV),
    .DEFAULT_PLEN (DP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .busy     (busy),
    .changed  (changed)
  );

  typedef struct {
    logic [15:0] out;
    logic        busy;
    logic        chg;
    logic [15:0] rd;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model: pulse tracked as an absolute fall edge, not a counter.
  logic [15:0] m_out, m_mask, m_plen;
  bit          m_active = 1'b0;
  bit          m_chg = 1'b0;
  int          m_deadline = 0;
  int          m_edge = 0;

  bit          c_rst_n = 1'b0;
  bit          c_cs = 1'b0;
  bit          c_wn = 1'b1;
  logic [2:0]  c_addr = 3'd0;
  logic [15:0] c_wd = 16'h0;

  task automatic model_edge();
    logic [15:0] old;
    m_edge++;
    if (!c_rst_n) begin
      m_out = RV; m_mask = 16'h0; m_plen = DP; m_active = 1'b0; m_chg = 1'b0;
    end else begin
      old = m_out;
      if (m_active && m_edge == m_deadline) begin
        m_out = m_out & ~m_mask; m_mask = 16'h0; m_active = 1'b0;
      end
      if (c_cs && !c_wn) begin
        case (c_addr)
          3'd0: begin m_out = c_wd; m_mask = 16'h0; m_active = 1'b0; end
          3'd1: m_out = m_out | c_wd;
          3'd2: begin m_out = m_out & ~c_wd; m_mask = m_mask & ~c_wd; end
          3'd3: m_out = m_out ^ c_wd;
          3'd4: if (c_wd != 16'h0) begin
            m_out = m_out | c_wd;
            m_mask = m_mask | c_wd;
            m_active = 1'b1;
            m_deadline = m_edge + ((m_plen == 16'h0) ? 1 : int'(m_plen));
          end
          3'd5: m_plen = c_wd;
          default: ;
        endcase
      end
      m_chg = (m_out != old);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return m_out;
      3'd4: return m_mask;
      3'd5: return m_plen;
      default: return 16'h0;
    endcase
  endfunction

  // Inputs given here are sampled by the DUT at the next rising edge.
  task automatic cyc(input bit rst_n, input bit cs, input bit wn,
                     input logic [2:0] a, input logic [15:0] wd);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    reset_n = rst_n; bus.chipselect = cs; bus.write_n = wn;
    bus.address = a; bus.writedata = wd;
    c_rst_n = rst_n; c_cs = cs; c_wn = wn; c_addr = a; c_wd = wd;
    e.out = m_out; e.busy = m_active; e.chg = m_chg;
    e.rd = model_rd(a); e.edge_n = m_edge;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] wd);
    cyc(1'b1, 1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b1, 1'b1, 1'b1, a, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
  endtask

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want, input int edge_n);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s after edge %0d: got %h expected %h", name, edge_n, got, want);
    end
  endtask

  // Monitor: compare DUT state against the scoreboard mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_port", out_port, e.out, e.edge_n);
        chk("busy", 16'(busy), 16'(e.busy), e.edge_n);
        chk("changed", 16'(changed), 16'(e.chg), e.edge_n);
        chk("readdata", bus.readdata, e.rd, e.edge_n);
      end
    end
  end

  initial begin
    logic [15:0] wd;
    int r;
    reset_n = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.address = 3'd0; bus.writedata = 16'h0;

    // Reset state and default PLEN readback
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    rd(3'd5);
    rd(3'd0);

    // Whole-word and atomic bit operations
    wr(3'd0, 16'h1234); idle(1);
    wr(3'd1, 16'h000F); idle(1);
    wr(3'd2, 16'h0204); idle(1);
    wr(3'd3, 16'hFF00); idle(1);
    wr(3'd1, 16'h0001); idle(1);

    // Basic pulse, PLEN = 5
    wr(3'd0, 16'h0000);
    wr(3'd5, 16'd5);
    wr(3'd4, 16'h0003);
    idle(7);

    // Retrigger extends both bits
    wr(3'd5, 16'd4);
    wr(3'd4, 16'h0001);
    idle(1);
    wr(3'd4, 16'h0002);
    rd(3'd4);
    idle(6);

    // DATA write cancels a running pulse
    wr(3'd4, 16'h0001);
    idle(1);
    wr(3'd0, 16'h0000);
    idle(6);

    // SET on the expiry edge wins
    wr(3'd5, 16'd2);
    wr(3'd4, 16'h0001);
    idle(1);
    wr(3'd1, 16'h0001);
    idle(3);

    // PLEN = 0 gives a one-cycle pulse
    wr(3'd5, 16'd0);
    wr(3'd4, 16'h0004);
    idle(3);

    // Reset mid-pulse, no late expiry
    wr(3'd5, 16'd3);
    wr(3'd4, 16'h0080);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 3'd1, 16'hFFFF);
    idle(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      case ($urandom_range(0, 2))
        0: wd = 16'($urandom);
        1: wd = 16'(1) << $urandom_range(0, 15);
        default: wd = 16'h0;
      endcase
      if (r < 1) begin
        cyc(1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)), wd);
      end else if (r < 70) begin
        idle(1);
      end else if (r < 100) begin
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b1,
            3'($urandom_range(0, 7)), wd);
      end else if (r < 110) begin
        cyc(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), wd);
      end else if (r < 120) begin
        wr(3'd5, 16'($urandom_range(0, 9)));
      end else begin
        wr(3'($urandom_range(0, 7)), wd);
      end
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_out_multi.md
# pio_out_multi

Parametrised Avalon-MM output PIO slave and successor to the fixed 16-bit data-out port. It drives a `WIDTH`-bit `out_port` from a register. Software can write that register whole, or use atomic per-bit SET/CLEAR/TOGGLE operations. A hardware pulse mode holds selected bits high for a programmable number of cycles, then clears them with no further bus traffic. It sits on the system interconnect as a zero-wait-state slave. Its `out_port` feeds board-level control lines.

## Interface
- `WIDTH`, 16: output port width, legal range 1..32.
- `PULSE_W`, 16: width of the pulse-length register and counter; must satisfy `PULSE_W <= WIDTH`.
- `RESET_VALUE`, 0: value of `out_port` after reset (`WIDTH` bits).
- `DEFAULT_PLEN`, 1: value of the PLEN register after reset.

- `clk` in 1: single system clock; all state changes on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `address` in 3: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: write strobe, active-low. A write occurs on a cycle with `chipselect && !write_n`.
- `writedata` in `WIDTH`: write data.
- `readdata` out `WIDTH`: combinational read data.
- `out_port` out `WIDTH`: the output register.
- `busy` out 1: a pulse is in progress (counter ≠ 0).
- `changed` out 1: one-cycle strobe, asserted the cycle after `out_port` changes value.

## Operation
- Address map, with write behaviour then read value:
  - 0 DATA: write sets `out_port = wd` and cancels any active pulse (mask = 0, counter = 0). Read returns `out_port`.
  - 1 SET: write sets `out_port |= wd`. Read returns 0.
  - 2 CLEAR: write sets `out_port &= ~wd` and `mask &= ~wd`. Read returns 0.
  - 3 TOGGLE: write sets `out_port ^= wd`. Read returns 0.
  - 4 PULSE: write sets `out_port |= wd` and `mask |= wd`, and loads the counter with `max(PLEN, 1)`. A write with `wd == 0` is ignored. Read returns `mask`.
  - 5 PLEN: write sets `PLEN = wd[PULSE_W-1:0]`. Read returns PLEN zero-extended. A PLEN write does not affect a pulse already running.
  - 6, 7: writes are ignored. Read returns 0.
- Pulse timer:
  - The counter decrements every cycle while it is non-zero.
  - On the edge where it goes from 1 to 0, the block applies `out_port &= ~mask` and sets mask = 0.
- Retrigger: a PULSE write during an active pulse reloads the counter and ORs in the new bits. All masked bits then share the extended deadline.
- When expiry and a register write land on the same edge, expiry is applied first and the write op second. The written bits therefore take the value the write specifies. A PULSE write on the expiry edge starts a fresh pulse whose mask holds only the new bits.
- Reset (any cycle, including mid-pulse) sets:
  - `out_port` = `RESET_VALUE`
  - mask = 0, counter = 0
  - PLEN = `DEFAULT_PLEN`
  - `busy` = 0, `changed` = 0
- `readdata` is a pure function of `address` and the current register state. It does not depend on `chipselect`.

## Timing
- A write is sampled at rising edge k. `out_port`, mask and PLEN show the new value after edge k.
- A PULSE write at edge k holds bits high for exactly `max(PLEN,1)` cycles. The bits fall after edge `k + max(PLEN,1)`.
- `busy` rises after edge k and falls on the same edge the bits fall.
- `changed` is high for the cycle after any edge where `out_port` changed value. A write that leaves the value unchanged produces no strobe.
- Reads complete in zero wait states: `readdata` is valid in the same cycle as `address`.
- Maximum PLEN is `2^PULSE_W − 1` cycles. The counter never wraps.

## Structure
- Shared package `pio_out_pkg` holds:
  - the address constants `ADDR_DATA` … `ADDR_PLEN`
  - a write-op enum (NONE/DATA/SET/CLR/TGL/PULSE/PLEN)
  - a decode function from address to op.
- Sub-module `pio_pulse_timer` (parameter `PULSE_W`):
  - inputs `load`, `load_val`
  - outputs `busy`, `expire` (one-cycle, on the 1→0 edge)
  - synchronous active-low reset.
- The top level holds `out_port`, mask, PLEN, the `changed` register and the read mux.

## Test plan
- Reset with `RESET_VALUE = 16'h00A5`: `out_port = 00A5`, `busy = 0`, `changed = 0`; reading address 5 returns 1.
- Write 0x1234 to DATA, then 0x000F to SET, then 0x0204 to CLEAR, then 0xFF00 to TOGGLE:
  - `out_port` steps through 1234, 123F, 103B, EF3B
  - `changed` pulses after each write.
- PLEN = 5, then PULSE 0x0003 at edge k: bits [1:0] are high for exactly 5 cycles and fall after edge k+5; `busy` matches.
- Retrigger:
  - setup: PLEN = 4, PULSE 0x1 at k, PULSE 0x2 at k+2
  - required: both bits fall together after edge k+6; reading address 4 at k+3 returns 0x3.
- Collisions:
  - DATA 0x0 written mid-pulse: pulse is cancelled, `busy` drops next edge, bits are not re-cleared later.
  - SET 0x1 on the expiry edge of pulse bit 0: bit 0 stays 1 after expiry.
- PLEN = 0 pulse gives a 1-cycle pulse. `reset_n` low mid-pulse gives `out_port = RESET_VALUE`, `busy = 0`, with no late expiry after release.
